// File: rtl/tk1_inv_pkg.sv
// Shared definitions for the inverse TK1 tweakey engine.
// Holds the command and FSM encodings, the reset image of the 8-byte state,
// the counter feedback tap mask and byte-level helpers for the state layout.
package tk1_inv_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD = 2'b00,
    CMD_RUN  = 2'b01,
    CMD_DEC  = 2'b10,
    CMD_READ = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_PERM = 2'd3
  } state_e;

  // Index i holds byte bi, so the flat 64-bit view reads b7 (MSB) .. b0 (LSB).
  typedef logic [7:0][7:0] tk1_state_t;

  // b7 = 0x01, everything else zero: counter value 1, domain 0.
  localparam tk1_state_t TK1_RST = 64'h01_00_00_00_00_00_00_00;

  // Forward counter feedback taps of x^56+x^7+x^4+x^2+1 (bits 7, 4, 2).
  localparam logic [55:0] LFSR_TAPS = 56'h94;

  // Counter view: {b1..b7}, b7 is the least-significant byte.
  function automatic logic [55:0] tk1_lfsr_view(input tk1_state_t s);
    return {s[1], s[2], s[3], s[4], s[5], s[6], s[7]};
  endfunction

  // Rebuild a full state from a counter value and a domain byte.
  function automatic tk1_state_t tk1_with_lfsr(input logic [55:0] v, input logic [7:0] b0);
    return {v[7:0], v[15:8], v[23:16], v[31:24], v[39:32], v[47:40], v[55:48], b0};
  endfunction

  // Inverse key-schedule byte permutation, result listed b7 down to b0.
  function automatic tk1_state_t tk1_perm_inv(input tk1_state_t s);
    return {s[5], s[7], s[3], s[0], s[1], s[4], s[2], s[6]};
  endfunction

endpackage

// File: rtl/tk1_lfsr_dec.sv
// Purpose : one backward step of the 56-bit TK1 block-counter LFSR.
// Latency : purely combinational.  Backpressure: none (no handshake).
// Ports   : y_i current counter value, x_o predecessor value.
module tk1_lfsr_dec
  import tk1_inv_pkg::*;
(
  input  logic [55:0] y_i,
  output logic [55:0] x_o
);

  // The forward step shifts left and feeds bit 55 into bit 0 and the taps.
  // Undo it: rotate right, then strip the feedback from the positions one
  // below each tap.
  assign x_o = {y_i[0], y_i[55:1]} ^ ({56{y_i[0]}} & (LFSR_TAPS >> 1));

endmodule

// File: rtl/tk1_inv.sv
// Purpose : byte-serial inverse TK1 tweakey engine; emits round keys last to
//           first and steps the block counter backwards.
// Latency : first key byte the cycle after RUN/READ accept; PERM adds one
//           cycle between round keys; DEC result visible the next cycle.
// Backpressure: ko_ready low freezes state, byte counter and ko.
// Ports   : cmd_* command handshake, din_* load bytes, domain for DEC,
//           ko_* key byte stream, lfsr counter view, busy/done status.
module tk1_inv
  import tk1_inv_pkg::*;
#(
  parameter int ROUNDS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [7:0]  domain,
  output logic [7:0]  ko,
  output logic        ko_valid,
  input  logic        ko_ready,
  output logic        ko_last,
  output logic [55:0] lfsr,
  output logic        busy,
  output logic        done
);

  localparam int RCW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  state_e           state_q, state_d;
  tk1_state_t       st_q;
  logic [2:0]       bc_q;
  logic [RCW-1:0]   rc_q;
  logic             done_q;
  logic [55:0]      lfsr_prev;
  logic             cmd_acc, din_acc, ko_acc;

  assign cmd_acc = cmd_valid && (state_q == ST_IDLE);
  assign din_acc = din_valid && (state_q == ST_LOAD);
  assign ko_acc  = ko_ready  && (state_q == ST_EMIT);

  assign lfsr = tk1_lfsr_view(st_q);
  assign ko   = st_q[7];
  assign done = done_q;

  tk1_lfsr_dec u_dec (
    .y_i (lfsr),
    .x_o (lfsr_prev)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          case (cmd_e'(cmd))
            CMD_LOAD:          state_d = ST_LOAD;
            CMD_RUN, CMD_READ: state_d = ST_EMIT;
            default:           state_d = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: if (din_acc && bc_q == 3'd7) state_d = ST_IDLE;
      // READ enters EMIT with rc = 0, so it ends after one key like the last RUN round.
      ST_EMIT: if (ko_acc && bc_q == 3'd7) state_d = (rc_q == '0) ? ST_IDLE : ST_PERM;
      ST_PERM: state_d = ST_EMIT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    cmd_ready = 1'b0;
    din_ready = 1'b0;
    ko_valid  = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_LOAD: din_ready = 1'b1;
      ST_EMIT: ko_valid  = 1'b1;
      default: ;
    endcase
    ko_last = ko_valid && (bc_q == 3'd7);
  end

  // Tweakey bytes, byte counter, round counter and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= TK1_RST;
      bc_q   <= '0;
      rc_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_acc) begin
            bc_q <= '0;
            case (cmd_e'(cmd))
              CMD_RUN:  rc_q <= RCW'(ROUNDS - 1);
              CMD_READ: rc_q <= '0;
              CMD_DEC:  st_q <= tk1_with_lfsr(lfsr_prev, domain);
              default:  ;
            endcase
          end
        end
        ST_LOAD: begin
          if (din_acc) begin
            st_q <= {st_q[6:0], din};
            bc_q <= bc_q + 3'd1;
          end
        end
        ST_EMIT: begin
          if (ko_acc) begin
            // Rotation: after eight accepts the key is back where it started.
            st_q <= {st_q[6:0], st_q[7]};
            bc_q <= bc_q + 3'd1;
            if (bc_q == 3'd7 && rc_q == '0) done_q <= 1'b1;
          end
        end
        ST_PERM: begin
          st_q <= tk1_perm_inv(st_q);
          rc_q <= rc_q - RCW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tk1_inv.sv
// Bench for tk1_inv: random stimulus, a byte-level reference model of the
// tweakey state, and a scoreboard monitor that checks every accepted ko byte.
module tb_tk1_inv;

  localparam int ROUNDS = 40;
  localparam logic [1:0] C_LOAD = 2'b00, C_RUN = 2'b01, C_DEC = 2'b10, C_READ = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd;
  logic [7:0]  din;
  logic        din_valid, din_ready;
  logic [7:0]  domain;
  logic [7:0]  ko;
  logic        ko_valid, ko_last, busy, done;
  logic        ko_ready = 1'b1;
  logic [55:0] lfsr;

  always #5 clk = ~clk;

  tk1_inv #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .domain(domain),
    .ko(ko), .ko_valid(ko_valid), .ko_ready(ko_ready), .ko_last(ko_last),
    .lfsr(lfsr), .busy(busy), .done(done)
  );

  int nvec = 0;
  int nerr = 0;
  int acc_cnt = 0;
  int last_cnt = 0;
  bit stall_en = 1'b0;
  bit offer_en = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_e;
  logic       hold_vld = 1'b0;
  logic [7:0] hold_ko;

  // Reference state: m[i] is byte bi.
  logic [7:0] m [8];
  // Inverse permutation as a source table: new b[i] = old b[src[i]].
  int src [8] = '{6, 2, 4, 1, 0, 3, 7, 5};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [55:0] mlfsr();
    return {m[1], m[2], m[3], m[4], m[5], m[6], m[7]};
  endfunction

  task automatic mset(input logic [55:0] v);
    for (int i = 1; i < 8; i++) m[i] = v[(7-i)*8 +: 8];
  endtask

  task automatic mreset();
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    m[7] = 8'h01;
  endtask

  task automatic mperm();
    logic [7:0] t [8];
    for (int i = 0; i < 8; i++) t[i] = m[src[i]];
    for (int i = 0; i < 8; i++) m[i] = t[i];
  endtask

  // One key leaves as b7, b6, ..., b0; the eighth byte carries ko_last.
  task automatic push_key();
    for (int j = 7; j >= 0; j--) exp_q.push_back({(j == 0), m[j]});
  endtask

  task automatic push_run();
    for (int r = 0; r < ROUNDS; r++) begin
      push_key();
      if (r < ROUNDS - 1) mperm();
    end
  endtask

  // Forward counter increment, written from the polynomial directly.
  function automatic logic [55:0] fwd(input logic [55:0] x);
    logic [55:0] y;
    y = {x[54:0], x[55]};
    if (x[55]) y = y ^ 56'h94;
    return y;
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_vld && ko_valid) chk("ko_stable", ko, hold_ko);
      hold_vld = 1'b0;
      if (ko_valid && ko_ready) begin
        acc_cnt++;
        if (ko_last) last_cnt++;
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL ko_unexpected: got 0x%0h expected no byte", ko);
        end else begin
          exp_e = exp_q.pop_front();
          chk("ko_byte", ko, exp_e[7:0]);
          chk("ko_last", ko_last, exp_e[8]);
        end
      end else if (ko_valid) begin
        hold_vld = 1'b1;
        hold_ko  = ko;
      end
    end else begin
      hold_vld = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    ko_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] c);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd = 2'($urandom);
  endtask

  // Runs until busy drops; optionally throws commands and din at the DUT meanwhile.
  task automatic wait_idle(output int cycles);
    int n = 0;
    while (busy && n < 4000) begin
      n++;
      if (offer_en) chk("cmd_ready_busy", cmd_ready, 0);
      tick();
      if (offer_en && busy) begin
        cmd_valid = 1'b1; cmd = 2'($urandom);
        din_valid = 1'b1; din = 8'($urandom); domain = 8'($urandom);
      end else begin
        cmd_valid = 1'b0; din_valid = 1'b0;
      end
    end
    cycles = n;
    if (busy) begin
      nvec++;
      nerr++;
      $display("FAIL idle_timeout: busy still %0d after %0d cycles", busy, n);
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic done_pulse();
    chk("done_high", done, 1);
    tick();
    chk("done_low", done, 0);
  endtask

  task automatic load(input logic [7:0] b [8]);
    issue(C_LOAD);
    for (int i = 0; i < 8; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        din_valid = 1'b0; din = 8'($urandom);
        tick();
      end
      chk("din_ready", din_ready, 1);
      din_valid = 1'b1;
      din = b[i];
      tick();
      din_valid = 1'b0;
    end
    for (int i = 0; i < 8; i++) m[7-i] = b[i];
    chk("load_lfsr", lfsr, mlfsr());
    chk("load_idle", busy, 0);
    chk("load_no_done", done, 0);
  endtask

  task automatic do_read();
    int cyc;
    push_key();
    issue(C_READ);
    wait_idle(cyc);
    done_pulse();
    chk("read_lfsr", lfsr, mlfsr());
  endtask

  task automatic do_run(input bit check_cycles);
    int cyc, l0;
    l0 = last_cnt;
    push_run();
    issue(C_RUN);
    chk("first_ko_valid", ko_valid, 1);
    wait_idle(cyc);
    if (check_cycles) chk("run_busy_cycles", cyc, ROUNDS*8 + ROUNDS - 1);
    chk("run_last_pulses", last_cnt - l0, ROUNDS);
    done_pulse();
    chk("run_lfsr", lfsr, mlfsr());
  endtask

  initial begin
    logic [7:0]  b [8];
    logic [55:0] r, f;
    logic [7:0]  d;
    int a0, n;

    rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00;
    din = 8'h00; din_valid = 1'b0; domain = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mreset();

    chk("rst_ko", ko, 8'h01);
    chk("rst_ko_valid", ko_valid, 0);
    chk("rst_ko_last", ko_last, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_din_ready", din_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lfsr", lfsr, 56'h1);

    // DEC straight out of reset.
    domain = 8'h1A;
    issue(C_DEC);
    chk("dec_lfsr", lfsr, 56'h8000000000004A);
    chk("dec_idle", busy, 0);
    mset(56'h8000000000004A);
    m[0] = 8'h1A;
    do_read();

    // Ascending load, READ, full RUN, READ.
    for (int i = 0; i < 8; i++) b[i] = 8'(i);
    load(b);
    do_read();
    do_run(1'b1);
    chk("run_final_lfsr", lfsr, 56'h04060205000701);
    do_read();

    // Same RUN under random backpressure, with commands thrown at the busy engine.
    load(b);
    stall_en = 1'b1; offer_en = 1'b1;
    do_run(1'b0);
    stall_en = 1'b0; offer_en = 1'b0;

    // Reset in the middle of round 5.
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    load(b);
    push_run();
    a0 = acc_cnt;
    issue(C_RUN);
    n = 0;
    while (acc_cnt < a0 + 35 && n < 1000) begin
      tick();
      n++;
    end
    chk("abort_reached_round5", acc_cnt - a0, 35);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    mreset();
    chk("abort_ko_valid", ko_valid, 0);
    chk("abort_ko", ko, 8'h01);
    chk("abort_busy", busy, 0);
    chk("abort_lfsr", lfsr, 56'h1);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", done, 0);
      tick();
    end

    // Round trips against the forward increment.
    for (int k = 0; k < 4; k++) begin
      r = {24'($urandom), 32'($urandom)};
      if (k == 0) r[55] = 1'b1;
      f = fwd(r);
      for (int i = 0; i < 7; i++) b[i] = f[i*8 +: 8];
      b[7] = 8'($urandom);
      load(b);
      d = 8'($urandom);
      domain = d;
      issue(C_DEC);
      chk("roundtrip_lfsr", lfsr, r);
      mset(r);
      m[0] = d;
      stall_en = 1'b1; offer_en = 1'b1;
      do_read();
      stall_en = 1'b0; offer_en = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
